// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared instruction, opcode and execution-stage types
//   OPERAND_W/RESULT_W : operand and result widths
//   opcode_t, instruction_t : instr_register word format
//   result_t, exec_state_t  : execution-stage result and FSM state
package instr_register_pkg;
    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = 2 * OPERAND_W;
    typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef struct packed {
        opcode_t                     opc;
        logic signed [OPERAND_W-1:0] op_a;
        logic [OPERAND_W-1:0]        op_b;
    } instruction_t;
    typedef logic signed [RESULT_W-1:0] result_t;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DIV, S_OUT} exec_state_t;
endpackage

// File: rtl/instr_exec_divider.sv
// instr_exec_divider: iterative restoring divider on magnitudes, OPERAND_W cycles per divide
//   clk, reset          : clock, synchronous active-high reset
//   start               : load dividend/divisor and begin
//   dividend, divisor   : signed dividend, unsigned non-zero divisor
//   busy, done          : divide in progress, final cycle
//   quotient, remainder : truncating quotient, remainder with dividend sign (valid while done)
module instr_exec_divider
    import instr_register_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [OPERAND_W-1:0] dividend,
    input  logic [OPERAND_W-1:0]        divisor,
    output logic                        busy,
    output logic                        done,
    output result_t                     quotient,
    output result_t                     remainder
);
    localparam int CW = $clog2(OPERAND_W + 1);
    logic [OPERAND_W-1:0] r_quo, r_rem, r_div, w_mag, w_quo_n, w_rem_n;
    logic [OPERAND_W:0]   w_shift;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg, w_ge;
    result_t              w_quo_x, w_rem_x;
    // Outputs reflect the step in flight, so on the done cycle they already
    // carry the final step and the caller can register them at that edge.
    always_comb begin
        w_mag     = dividend[OPERAND_W-1] ? -dividend : dividend;
        w_shift   = {r_rem, r_quo[OPERAND_W-1]};
        w_ge      = w_shift >= {1'b0, r_div};
        w_rem_n   = w_ge ? OPERAND_W'(w_shift - {1'b0, r_div}) : w_shift[OPERAND_W-1:0];
        w_quo_n   = {r_quo[OPERAND_W-2:0], w_ge};
        w_quo_x   = {{(RESULT_W-OPERAND_W){1'b0}}, w_quo_n};
        w_rem_x   = {{(RESULT_W-OPERAND_W){1'b0}}, w_rem_n};
        quotient  = r_neg ? -w_quo_x : w_quo_x;
        remainder = r_neg ? -w_rem_x : w_rem_x;
    end
    assign busy = r_cnt != '0;
    assign done = r_cnt == CW'(1);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
            r_neg <= 1'b0;
            r_cnt <= '0;
        end else if (start) begin
            r_quo <= w_mag;
            r_rem <= '0;
            r_div <= divisor;
            r_neg <= dividend[OPERAND_W-1];
            r_cnt <= CW'(OPERAND_W);
        end else if (busy) begin
            r_quo <= w_quo_n;
            r_rem <= w_rem_n;
            r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/instr_exec_unit.sv
// instr_exec_unit: execution stage walking instr_register locations and computing results
//   clk, reset                     : clock, synchronous active-high reset
//   start, first_ptr, num_instr    : run request (sampled in IDLE), first location, count 0..32
//   read_pointer, instruction_word : instr_register read port
//   busy, done                     : run in progress, one-cycle end-of-run pulse
//   result_valid/ready, result, result_opc, result_ptr, div_by_zero : result channel
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PTR_W-1:0] first_ptr,
    input  logic [PTR_W:0]   num_instr,
    output logic [PTR_W-1:0] read_pointer,
    input  instruction_t     instruction_word,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output result_t          result,
    output opcode_t          result_opc,
    output logic [PTR_W-1:0] result_ptr,
    output logic             div_by_zero,
    output logic             done
);
    localparam int LW = PTR_W + 1;
    exec_state_t      r_state, w_next;
    logic [PTR_W-1:0] r_ptr, r_res_ptr;
    logic [PTR_W:0]   r_left;
    instruction_t     r_instr;
    result_t          r_result, w_exec, w_a, w_b, w_quo, w_rem;
    opcode_t          r_opc;
    logic             r_dbz, r_done, w_done, w_is_div, w_div_start, w_div_busy, w_div_done;
    logic             w_last, w_xfer;
    assign w_is_div    = r_instr.opc == DIV || r_instr.opc == MOD;
    assign w_div_start = r_state == S_EXEC && w_is_div && r_instr.op_b != '0;
    assign w_last      = r_left == LW'(1);
    assign w_xfer      = r_state == S_OUT && result_ready;
    instr_exec_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (w_div_start),
        .dividend  (r_instr.op_a),
        .divisor   (r_instr.op_b),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );
    always_comb begin
        w_a = {{(RESULT_W-OPERAND_W){r_instr.op_a[OPERAND_W-1]}}, r_instr.op_a};
        w_b = {{(RESULT_W-OPERAND_W){1'b0}}, r_instr.op_b};
        case (r_instr.opc)
            PASSA:   w_exec = w_a;
            PASSB:   w_exec = w_b;
            ADD:     w_exec = w_a + w_b;
            SUB:     w_exec = w_a - w_b;
            MULT:    w_exec = w_a * w_b;
            default: w_exec = '0;
        endcase
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = start && num_instr != '0 ? S_FETCH : S_IDLE;
                w_done = start && num_instr == '0;
            end
            S_FETCH: w_next = S_EXEC;
            S_EXEC:  w_next = w_div_start ? S_DIV : S_OUT;
            S_DIV:   w_next = w_div_done ? S_OUT : S_DIV;
            S_OUT: begin
                w_next = w_xfer ? (w_last ? S_IDLE : S_FETCH) : S_OUT;
                w_done = w_xfer && w_last;
            end
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr     <= '0;
            r_left    <= '0;
            r_instr   <= '0;
            r_result  <= '0;
            r_opc     <= ZERO;
            r_res_ptr <= '0;
            r_dbz     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_done;
            if (r_state == S_IDLE && w_next == S_FETCH) begin
                r_ptr  <= first_ptr;
                r_left <= num_instr;
            end
            if (r_state == S_FETCH) r_instr <= instruction_word;
            if (r_state == S_EXEC) begin
                r_result  <= w_exec;
                r_opc     <= r_instr.opc;
                r_res_ptr <= r_ptr;
                r_dbz     <= w_is_div && !w_div_start;
            end
            if (r_state == S_DIV && w_div_done) r_result <= r_opc == DIV ? w_quo : w_rem;
            if (w_xfer) begin
                r_left <= r_left - LW'(1);
                r_ptr  <= w_last ? r_ptr : r_ptr + PTR_W'(1);
            end
        end
    end
    assign read_pointer = r_ptr;
    assign busy         = r_state != S_IDLE || w_div_busy;
    assign result_valid = r_state == S_OUT;
    assign result       = r_result;
    assign result_opc   = r_opc;
    assign result_ptr   = r_res_ptr;
    assign div_by_zero  = r_dbz;
    assign done         = r_done;
endmodule

// File: tb/tb_instr_exec_unit.sv
// tb_instr_exec_unit: directed runs against a behavioural result model with a per-cycle compare
module tb_instr_exec_unit;
    import instr_register_pkg::*;
    localparam int PTR_W = 5;
    typedef struct {
        int res;
        int opc;
        int ptr;
        int dbz;
    } exp_t;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             result_ready = 1'b0;
    logic [PTR_W-1:0] first_ptr = '0;
    logic [PTR_W:0]   num_instr = '0;
    logic [PTR_W-1:0] read_pointer, result_ptr;
    instruction_t     instruction_word;
    logic             busy, result_valid, div_by_zero, done;
    result_t          result;
    opcode_t          result_opc;
    instruction_t     mem [32];
    exp_t             exp_q [$];
    int               checks = 0, errors = 0, cyc = 0;
    int               fv, dk, r0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign instruction_word = mem[read_pointer];

    instr_exec_unit #(.PTR_W(PTR_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_ptr        (first_ptr),
        .num_instr        (num_instr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .busy             (busy),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result           (result),
        .result_opc       (result_opc),
        .result_ptr       (result_ptr),
        .div_by_zero      (div_by_zero),
        .done             (done)
    );

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic setm(input int p, input opcode_t o, input int a, input int b);
        mem[p] = '{o, a[OPERAND_W-1:0], b[OPERAND_W-1:0]};
    endtask

    // Result rules stated directly with integer arithmetic: SV / truncates
    // toward zero and % takes the dividend's sign.
    function automatic exp_t model(input int p);
        exp_t e;
        int a, b;
        opcode_t o;
        o = mem[p].opc;
        a = int'($signed(mem[p].op_a));
        b = int'(mem[p].op_b);
        e.opc = int'(o);
        e.ptr = p;
        e.dbz = ((o == DIV || o == MOD) && b == 0) ? 1 : 0;
        case (o)
            PASSA:   e.res = a;
            PASSB:   e.res = b;
            ADD:     e.res = a + b;
            SUB:     e.res = a - b;
            MULT:    e.res = a * b;
            DIV:     e.res = (b == 0) ? 0 : a / b;
            MOD:     e.res = (b == 0) ? 0 : a % b;
            default: e.res = 0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && result_valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                chk("result", result, exp_q[0].res);
                chk("result_opc", result_opc, exp_q[0].opc);
                chk("result_ptr", result_ptr, exp_q[0].ptr);
                chk("div_by_zero", div_by_zero, exp_q[0].dbz);
                chk("busy_in_out", busy, 1);
                if (result_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_read_pointer"}, read_pointer, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_opc"}, result_opc, 0);
        chk({tag, "_result_ptr"}, result_ptr, 0);
        chk({tag, "_div_by_zero"}, div_by_zero, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // k counts cycles after the edge that samples start; fv/dk are the k at
    // which result_valid first shows and done shows, r0 the first result.
    task automatic run(input int fp, input int n, input bit hold, output int fv_o, output int dk_o, output int r0_o);
        int c0, k, held, rp_i;
        bit fetch, xfer;
        logic [PTR_W-1:0] rp_hold;
        for (int i = 0; i < n; i++) exp_q.push_back(model((fp + i) % 32));
        result_ready = !hold;
        @(posedge clk);
        #1;
        start = 1'b1;
        first_ptr = PTR_W'(fp);
        num_instr = (PTR_W+1)'(n);
        c0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        fv_o = -1;
        dk_o = -1;
        r0_o = 0;
        held = 0;
        rp_i = 0;
        xfer = 1'b0;
        rp_hold = '0;
        for (int t = 0; t < 300 && dk_o < 0; t++) begin
            @(negedge clk);
            k = cyc - (c0 + 1);
            fetch = (k == 0) || xfer;
            xfer = result_valid && result_ready;
            if (done) begin
                dk_o = k;
                chk("idle_busy", busy, 0);
                chk("idle_valid", result_valid, 0);
            end else if (fetch) begin
                chk("read_pointer", read_pointer, (fp + rp_i) % 32);
                rp_i++;
            end
            if (result_valid && fv_o < 0) begin
                fv_o = k;
                r0_o = int'(result);
            end
            if (hold && result_valid && !result_ready) begin
                if (held == 0) rp_hold = read_pointer;
                else chk("hold_read_pointer", read_pointer, rp_hold);
                held++;
                if (held == 5) begin
                    @(posedge clk);
                    #1 result_ready = 1'b1;
                end
            end
        end
        if (dk_o < 0) chk("run_timeout", 0, 1);
        chk("fetch_count", rp_i, n);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        setm(0, ADD, 5, 3);
        setm(1, MULT, -8, 15);
        setm(2, MULT, 7, 15);
        setm(3, DIV, -7, 3);
        setm(4, MOD, -7, 3);
        setm(5, DIV, 6, 0);
        setm(6, PASSB, 1, 9);
        setm(7, ZERO, 5, 5);
        setm(8, DIV, -8, 1);
        setm(9, MOD, 5, 4);
        setm(30, SUB, -8, 15);
        setm(31, PASSA, -3, 2);
        chk("model_mult_neg", model(1).res, -120);
        chk("model_div", model(3).res, -2);
        chk("model_mod", model(4).res, -1);
        chk("model_dbz", model(5).dbz, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        run(0, 1, 1'b0, fv, dk, r0);
        chk("add_latency", fv, 2);
        chk("add_result", r0, 8);
        chk("add_done", dk, 3);
        run(1, 2, 1'b0, fv, dk, r0);
        chk("mult_latency", fv, 2);
        chk("mult_result", r0, -120);
        chk("mult_done", dk, 6);
        run(3, 3, 1'b0, fv, dk, r0);
        chk("div_latency", fv, 6);
        chk("div_result", r0, -2);
        chk("div_done", dk, 17);
        run(30, 3, 1'b0, fv, dk, r0);
        chk("wrap_latency", fv, 2);
        chk("wrap_result", r0, -23);
        chk("wrap_done", dk, 9);
        run(2, 1, 1'b1, fv, dk, r0);
        chk("hold_latency", fv, 2);
        chk("hold_result", r0, 105);
        chk("hold_done", dk, 8);
        run(0, 0, 1'b0, fv, dk, r0);
        chk("zero_run_valid", fv, -1);
        chk("zero_run_done", dk, 0);
        run(6, 4, 1'b0, fv, dk, r0);
        chk("mix_result", r0, 9);
        chk("mix_done", dk, 20);
        @(posedge clk);
        #1;
        start = 1'b1;
        first_ptr = 5'd3;
        num_instr = 6'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_div_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("mid_div_reset");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_reset_valid", result_valid, 0);
        end
        run(0, 1, 1'b0, fv, dk, r0);
        chk("restart_latency", fv, 2);
        chk("restart_result", r0, 8);
        chk("restart_done", dk, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
